fan_pi_seq: RTL and testbench
=============================

# fan_pi_seq

Discrete PI control sequencer for the 4-bit fan controller, directly upstream of the serial signed multiplier. On every sample tick it computes the speed error and updates a saturating integrator. It issues two multiplier jobs, Kp·e and Ki·integ, each with a start strobe and a wait for the done strobe. It then sums and clamps the results into an unsigned N-bit duty word for the PWM stage.

## Interface
- `N`, 4 — operand width; internal signed width is 2N.
- `KP`, 3 — proportional gain, signed 2N-bit.
- `KI`, 1 — integral gain, signed 2N-bit.
- `SAMPLE_DIV`, 1000 — clocks per control sample; minimum 4.

Ports:
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  control loop enable.
- `setpoint_i`  in  N  target speed, unsigned.
- `actual_i`  in  N  measured speed, unsigned.
- `MUL_Start_STRB_o`  out  1  one-cycle start to the multiplier.
- `MUL_Done_STRB_i`  in  1  one-cycle done from the multiplier.
- `mul_a_o`  out  2N  signed multiplicand (gain).
- `mul_b_o`  out  2N  signed multiplier (error or integrator).
- `mul_out_i`  in  2N  signed product, valid when done is high.
- `duty_o`  out  N  duty command, unsigned.
- `duty_valid_o`  out  1  one-cycle strobe when `duty_o` is updated.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Sample counter `tick_cnt` runs 0..SAMPLE_DIV-1 and wraps while `enable_i`=1. It is held at 0 while `enable_i`=0. Tick = (cnt==SAMPLE_DIV-1).
- FSM states: IDLE, START_P, WAIT_P, START_I, WAIT_I, UPDATE.
- IDLE → START_P on tick. On that edge:
  - error e = zext(setpoint_i) − zext(actual_i), signed 2N, range −(2^N−1)..2^N−1.
  - integ ← sat2N(integ + e), clamped to [−2^(2N−1), 2^(2N−1)−1].
- START_P: `MUL_Start_STRB_o`=1, `mul_a_o`=KP, `mul_b_o`=e. Always → WAIT_P.
- WAIT_P: on `MUL_Done_STRB_i`, p ← `mul_out_i`, → START_I.
- START_I: strobe with `mul_a_o`=KI, `mul_b_o`=integ. → WAIT_I.
- WAIT_I: on done, i ← `mul_out_i`, → UPDATE.
- UPDATE: s = p + i at 2N+1 bits.
  - `duty_o` ← 0 if s<0; 2^N−1 if s>2^N−1; else s[N-1:0].
  - sat_hi / sat_lo flags record which clamp fired.
  - → IDLE.
- Operands: `mul_a_o` and `mul_b_o` are registered and held stable from START_x until the next START_x.
- Products are treated as 2N-bit signed. Truncation is the multiplier's responsibility.
- `enable_i` falling in any state aborts to IDLE next cycle. `duty_o` and integ are held; no `duty_valid_o`.
- Tick while not IDLE: dropped, no queueing.
- Done strobe outside WAIT_P/WAIT_I: ignored.

## Timing
- Reset values: `MUL_Start_STRB_o`=0, `mul_a_o`=0, `mul_b_o`=0, `duty_o`=0, `duty_valid_o`=0, `busy_o`=0. Internal: integ=0, p=0, i=0, sat flags=0, tick_cnt=0, state IDLE.
- Reset is asynchronous and acts mid-operation. The FSM returns to IDLE immediately; the multiplier is not notified, and its stray done is ignored.
- Tick edge → `MUL_Start_STRB_o` high 1 cycle later, for exactly 1 cycle.
- Done in WAIT_I at cycle T → UPDATE at T+1 → `duty_o` and `duty_valid_o` visible at T+2. `duty_valid_o` is high for exactly 1 cycle.
- Total latency = 2 + L_P + L_I + 2 cycles, where L_x is the multiplier latency from start to done.

## Configuration
- `FAN_PI_ANTIWINDUP_EN` defined: the integrator update on tick is skipped when it would deepen the previous clamp:
  - sat_hi=1 and e>0, or
  - sat_lo=1 and e<0.
- Not defined: integ always updates, bounded only by 2N-bit saturation.

## Test plan
- Bench uses a behavioural multiplier: done 5 cycles after start, product = a·b truncated to 2N bits. KP=3, KI=1, N=4.
- Reset, enable=1, setpoint=8, actual=6 → e=2, integ=2, p=6, i=2, `duty_o`=8 with one `duty_valid_o`. Next sample: integ=4, `duty_o`=10.
- setpoint=0, actual=15 → e=−15, s=−60 → `duty_o`=0. Repeat 10 samples:
  - with `FAN_PI_ANTIWINDUP_EN`, integ stays −15;
  - without it, integ reaches −128 and holds.
- setpoint=15, actual=0 → s=60 → `duty_o`=15. Verify exactly 2 start strobes per sample with operands (3,15) then (1,15).
- Drop `enable_i` during WAIT_I → back to IDLE next cycle; `duty_o` unchanged, no `duty_valid_o`, and the late done is ignored.
- Assert `rstn_i` low mid WAIT_P → all outputs and integ read 0 asynchronously. After release, the first result equals the fresh-start value.

Source files
------------

// File: rtl/fan_pi_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fan_pi_seq_if : multiplier job handshake between sequencer and multiplier  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fan_pi_seq_if #(
    parameter int N = 4
);
    logic                  MUL_Start_STRB_o;
    logic                  MUL_Done_STRB_i;
    logic signed [2*N-1:0] mul_a_o;
    logic signed [2*N-1:0] mul_b_o;
    logic signed [2*N-1:0] mul_out_i;

    modport master (
        output MUL_Start_STRB_o,
        output mul_a_o,
        output mul_b_o,
        input  MUL_Done_STRB_i,
        input  mul_out_i
    );

    modport slave (
        input  MUL_Start_STRB_o,
        input  mul_a_o,
        input  mul_b_o,
        output MUL_Done_STRB_i,
        output mul_out_i
    );
endinterface
`default_nettype wire

// File: rtl/fan_pi_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fan_pi_seq : sampled PI sequencer driving a shared serial multiplier,     |
// | clamps Kp*e + Ki*integ into an unsigned duty word.                          |
// | Optional: FAN_PI_ANTIWINDUP_EN freezes the integrator on a deepening clamp.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fan_pi_seq #(
    parameter int                    N          = 4,
    parameter logic signed [2*N-1:0] KP         = 3,
    parameter logic signed [2*N-1:0] KI         = 1,
    parameter int                    SAMPLE_DIV = 1000
) (
    input  wire logic         clk_i,
    input  wire logic         rstn_i,
    input  wire logic         enable_i,
    input  wire logic [N-1:0] setpoint_i,
    input  wire logic [N-1:0] actual_i,
    fan_pi_seq_if.master      mul,
    output logic [N-1:0]      duty_o,
    output logic              duty_valid_o,
    output logic              busy_o
);
    localparam int c_W     = 2 * N;
    localparam int c_CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic signed [c_W-1:0] c_IMAX = {1'b0, {(c_W-1){1'b1}}};
    localparam logic signed [c_W-1:0] c_IMIN = {1'b1, {(c_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START_P = 3'd1,
        S_WAIT_P  = 3'd2,
        S_START_I = 3'd3,
        S_WAIT_I  = 3'd4,
        S_UPDATE  = 3'd5
    } state_t;

    state_t                r_state, w_state_next;
    logic [c_CNT_W-1:0]    r_tick_cnt;
    logic signed [c_W-1:0] r_integ, r_p, r_i, r_mul_a, r_mul_b;
    logic                  r_sat_hi, r_sat_lo;
    logic [N-1:0]          r_duty;
    logic                  r_duty_valid;

    logic                  w_tick, w_hold;
    logic signed [c_W-1:0] w_err, w_integ_sat;
    logic signed [c_W:0]   w_isum, w_sum;
    logic                  w_sum_lo, w_sum_hi;
    logic [N-1:0]          w_duty;

    assign w_tick = enable_i && (r_tick_cnt == c_TICK_LAST);
    assign w_err  = $signed({{N{1'b0}}, setpoint_i}) - $signed({{N{1'b0}}, actual_i});

    assign w_isum = {r_integ[c_W-1], r_integ} + {w_err[c_W-1], w_err};
    always_comb begin
        w_integ_sat = w_isum[c_W-1:0];
        case (w_isum[c_W:c_W-1])
            2'b01:   w_integ_sat = c_IMAX;
            2'b10:   w_integ_sat = c_IMIN;
            default: w_integ_sat = w_isum[c_W-1:0];
        endcase
    end

`ifdef FAN_PI_ANTIWINDUP_EN
    assign w_hold = (r_sat_hi && !w_err[c_W-1] && (w_err != '0)) ||
                    (r_sat_lo &&  w_err[c_W-1]);
`else
    logic w_unused_sat;
    assign w_hold       = 1'b0;
    assign w_unused_sat = r_sat_hi ^ r_sat_lo;
`endif

    // Sum kept one bit wider so neither operand extreme can wrap.
    assign w_sum    = {r_p[c_W-1], r_p} + {r_i[c_W-1], r_i};
    assign w_sum_lo = w_sum[c_W];
    assign w_sum_hi = !w_sum[c_W] && (w_sum[c_W-1:N] != '0);
    assign w_duty   = w_sum_lo ? '0 : (w_sum_hi ? '1 : w_sum[N-1:0]);

    always_comb begin
        w_state_next         = r_state;
        mul.MUL_Start_STRB_o = 1'b0;
        busy_o               = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    if (w_tick) w_state_next = S_START_P;
            S_START_P: begin
                mul.MUL_Start_STRB_o = 1'b1;
                w_state_next         = S_WAIT_P;
            end
            S_WAIT_P:  if (mul.MUL_Done_STRB_i) w_state_next = S_START_I;
            S_START_I: begin
                mul.MUL_Start_STRB_o = 1'b1;
                w_state_next         = S_WAIT_I;
            end
            S_WAIT_I:  if (mul.MUL_Done_STRB_i) w_state_next = S_UPDATE;
            S_UPDATE:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        if (!enable_i) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tick_cnt   <= '0;
            r_integ      <= '0;
            r_p          <= '0;
            r_i          <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
            r_duty       <= '0;
            r_duty_valid <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            if (!enable_i || (r_tick_cnt == c_TICK_LAST)) r_tick_cnt <= '0;
            else                                          r_tick_cnt <= r_tick_cnt + c_CNT_W'(1);

            if (r_state == S_IDLE && w_tick) begin
                if (!w_hold) r_integ <= w_integ_sat;
                r_mul_a <= KP;
                r_mul_b <= w_err;
            end
            // r_integ already holds this sample's update when the I job loads.
            if (r_state == S_WAIT_P && w_state_next == S_START_I) begin
                r_p     <= mul.mul_out_i;
                r_mul_a <= KI;
                r_mul_b <= r_integ;
            end
            if (r_state == S_WAIT_I && w_state_next == S_UPDATE) r_i <= mul.mul_out_i;
            if (r_state == S_UPDATE && enable_i) begin
                r_duty       <= w_duty;
                r_duty_valid <= 1'b1;
                r_sat_hi     <= w_sum_hi;
                r_sat_lo     <= w_sum_lo;
            end
        end
    end

    assign mul.mul_a_o  = r_mul_a;
    assign mul.mul_b_o  = r_mul_b;
    assign duty_o       = r_duty;
    assign duty_valid_o = r_duty_valid;
endmodule
`default_nettype wire

// File: tb/tb_fan_pi_seq.sv
`default_nettype none
// Randomised bench for fan_pi_seq: behavioural 5-cycle multiplier plus an
// arithmetic PI reference model.
module tb_fan_pi_seq;
    localparam int N   = 4;
    localparam int DIV = 32;
    localparam int KP  = 3;
    localparam int KI  = 1;
`ifdef FAN_PI_ANTIWINDUP_EN
    localparam bit AW = 1'b1;
`else
    localparam bit AW = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         rstn   = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] sp     = '0;
    logic [N-1:0] act    = '0;
    logic [N-1:0] duty;
    logic         dv, busy;

    fan_pi_seq_if #(.N(N)) mif ();

    fan_pi_seq #(
        .N(N), .KP(8'sd3), .KI(8'sd1), .SAMPLE_DIV(DIV)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
        .setpoint_i(sp), .actual_i(act), .mul(mif.master),
        .duty_o(duty), .duty_valid_o(dv), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: done exactly 5 cycles after the start cycle.
    int                 mcnt = 0;
    logic signed [7:0]  ma = '0, mb = '0;
    logic signed [15:0] mprod;
    assign mprod = ma * mb;
    always @(posedge clk) begin
        mif.MUL_Done_STRB_i <= 1'b0;
        if (mif.MUL_Start_STRB_o) begin
            ma   <= mif.mul_a_o;
            mb   <= mif.mul_b_o;
            mcnt <= 4;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mif.MUL_Done_STRB_i <= 1'b1;
                mif.mul_out_i       <= mprod[7:0];
            end
        end
    end

    logic [15:0]  opq[$];
    int           vcnt = 0;
    logic [N-1:0] last_duty = '0;
    always begin
        @(posedge clk);
        #1;
        if (mif.MUL_Start_STRB_o) opq.push_back({mif.mul_a_o, mif.mul_b_o});
        if (dv) begin
            vcnt++;
            last_duty = duty;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model
    int m_integ = 0, m_e = 0, m_duty = 0, obs_i = 0;
    bit m_hi = 1'b0, m_lo = 1'b0;

    function automatic int sx8(input int v);
        logic [7:0] t;
        t = v[7:0];
        return int'($signed(t));
    endfunction

    task automatic model_reset();
        m_integ = 0; m_duty = 0; m_hi = 1'b0; m_lo = 1'b0;
    endtask

    task automatic model_tick(input int s, input int a);
        bit skip;
        m_e  = s - a;
        skip = AW && ((m_hi && m_e > 0) || (m_lo && m_e < 0));
        if (!skip) begin
            m_integ = m_integ + m_e;
            if (m_integ > 127)  m_integ = 127;
            if (m_integ < -128) m_integ = -128;
        end
    endtask

    task automatic model_update();
        int p, i, s;
        p = sx8(KP * m_e);
        i = sx8(KI * m_integ);
        s = p + i;
        m_lo   = (s < 0);
        m_hi   = (s > 15);
        m_duty = m_lo ? 0 : (m_hi ? 15 : s);
    endtask

    task automatic run_sample(input string tag);
        int          n;
        logic [15:0] t;
        opq.delete();
        vcnt = 0;
        n    = 0;
        while (vcnt == 0 && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, int'(vcnt > 0), 1);
        model_tick(int'(sp), int'(act));
        model_update();
        chk({tag, "_duty"}, int'(last_duty), m_duty);
        chk({tag, "_nstart"}, opq.size(), 2);
        obs_i = 999;
        if (opq.size() == 2) begin
            chk({tag, "_opP"}, int'(opq[0]), int'({8'(KP), 8'(m_e)}));
            chk({tag, "_opI"}, int'(opq[1]), int'({8'(KI), 8'(m_integ)}));
            t     = opq[1];
            obs_i = sx8(int'(t[7:0]));
        end
        @(negedge clk);
        chk({tag, "_vpulse"}, vcnt, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn   = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"},  int'(duty), 0);
        chk({tag, "_dv"},    int'(dv), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_start"}, int'(mif.MUL_Start_STRB_o), 0);
        chk({tag, "_a"},     int'(mif.mul_a_o), 0);
        chk({tag, "_b"},     int'(mif.mul_b_o), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rstn = 1'b1;
        model_reset();

        sp = 4'd8; act = 4'd6; enable = 1'b1;
        run_sample("s1");
        chk("s1_const", int'(last_duty), 8);
        run_sample("s2");
        chk("s2_const", int'(last_duty), 10);

        do_reset();
        enable = 1'b1; sp = 4'd0; act = 4'd15;
        for (int k = 0; k < 10; k++) begin
            run_sample("neg");
            chk("neg_const", int'(last_duty), 0);
        end
        chk("neg_integ", obs_i, AW ? -15 : -128);

        do_reset();
        enable = 1'b1; sp = 4'd15; act = 4'd0;
        run_sample("pos");
        chk("pos_const", int'(last_duty), 15);
        chk("pos_integ", obs_i, 15);

        // Abort in WAIT_I: integrator keeps the tick update, duty does not move.
        sp = 4'd12; act = 4'd4;
        opq.delete();
        vcnt = 0;
        n    = 0;
        while (opq.size() < 2 && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", int'(opq.size() >= 2), 1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        model_tick(int'(sp), int'(act));
        repeat (12) @(negedge clk);
        chk("abort_novalid", vcnt, 0);
        chk("abort_duty", int'(duty), m_duty);
        chk("abort_late", int'(busy), 0);
        enable = 1'b1;
        run_sample("post_abort");

        // Asynchronous reset while waiting on the P product.
        opq.delete();
        n = 0;
        while (opq.size() < 1 && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", int'(opq.size() >= 1), 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero("arst");
        repeat (8) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        sp = 4'd8; act = 4'd6;
        run_sample("fresh");
        chk("fresh_const", int'(last_duty), 8);
        chk("fresh_integ", obs_i, 2);

        for (int k = 0; k < 20; k++) begin
            sp  = 4'($urandom_range(0, 15));
            act = 4'($urandom_range(0, 15));
            run_sample("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
